// File: rtl/obstacle_scheduler_pkg.sv
// Shared definitions for the obstacle scheduler, renderer and game_logic:
// game modes, screen geometry, slot bus field layout and the scheduler FSM encoding.
package obstacle_scheduler_pkg;

    typedef enum logic [1:0] {
        GM_INIT  = 2'b00,
        GM_RUN   = 2'b01,
        GM_PAUSE = 2'b10,
        GM_OVER  = 2'b11
    } gamemode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SCROLL = 2'b01,
        ST_SPAWN  = 2'b10,
        ST_CLEAR  = 2'b11
    } sched_state_t;

    localparam int N_SLOTS      = 10;
    localparam int IDX_W        = 4;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int X_FIELD_W    = 20;
    localparam int Y_FIELD_W    = 18;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SPEED    = 4;

    // Right edge of a freshly spawned obstacle, saturated at the 10-bit limit.
    function automatic logic [X_W-1:0] spawn_right_edge(input logic [X_W-1:0] left,
                                                        input logic [X_W-1:0] width);
        logic [X_W:0] sum;
        sum = {1'b0, left} + {1'b0, width};
        return sum[X_W] ? {X_W{1'b1}} : sum[X_W-1:0];
    endfunction

endpackage

// File: rtl/obstacle_slot_alloc.sv
// Lowest-free-slot priority encoder over the active mask.
module obstacle_slot_alloc
    import obstacle_scheduler_pkg::*;
(
    input  logic [N_SLOTS-1:0] active_mask,
    output logic [IDX_W-1:0]   free_idx,
    output logic               none_free
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        free_idx  = {IDX_W{1'b0}};
        none_free = &active_mask;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            free_idx = active_mask[i] ? free_idx : IDX_W'(i);
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Owns the obstacle slots: places spawned obstacles, scrolls live ones once per
// frame with a one-slot-per-cycle sweep, and retires those that leave the screen.
module obstacle_scheduler
    import obstacle_scheduler_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SPEED    = DEF_SPEED
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    gamemode,
    input  logic                          frame_tick,
    input  logic                          spawn_req,
    input  logic [X_W-1:0]                spawn_width,
    input  logic [Y_W-1:0]                spawn_y_top,
    input  logic [Y_W-1:0]                spawn_y_bot,
    output logic                          spawn_ack,
    output logic                          spawn_ok,
    output logic [N_SLOTS*X_FIELD_W-1:0]  obstacle_x,
    output logic [N_SLOTS*Y_FIELD_W-1:0]  obstacle_y,
    output logic [N_SLOTS-1:0]            active_mask,
    output logic                          tick_overrun
);

    localparam logic [X_W-1:0]   SCREEN_X = X_W'(SCREEN_W);
    localparam logic [X_W-1:0]   SPEED_X  = X_W'(SPEED);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLOTS - 1);

    sched_state_t       state_r;
    sched_state_t       state_s;
    logic [IDX_W-1:0]   idx_r;
    logic               tick_pend_r;
    logic               tick_overrun_r;
    logic               spawn_ack_r;
    logic               spawn_ok_r;
    logic [IDX_W-1:0]   spawn_slot_r;
    logic [X_W-1:0]     spawn_right_r;
    logic [Y_W-1:0]     spawn_top_r;
    logic [Y_W-1:0]     spawn_bot_r;

    logic [X_W-1:0]     left_r  [N_SLOTS];
    logic [X_W-1:0]     right_r [N_SLOTS];
    logic [Y_W-1:0]     top_r   [N_SLOTS];
    logic [Y_W-1:0]     bot_r   [N_SLOTS];
    logic [N_SLOTS-1:0] active_r;

    logic [IDX_W-1:0]   free_idx_s;
    logic               none_free_s;
    logic               spawn_valid_s;
    logic               go_spawn_s;

    obstacle_slot_alloc u_alloc (
        .active_mask (active_r),
        .free_idx    (free_idx_s),
        .none_free   (none_free_s)
    );

    assign spawn_valid_s = (spawn_width != {X_W{1'b0}}) && (spawn_y_top < spawn_y_bot) && !none_free_s;
    assign go_spawn_s    = (state_r == ST_IDLE) && (state_s == ST_SPAWN);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decision; mode is only sampled in IDLE so a started sweep always finishes.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (gamemode == GM_INIT) begin
                    state_s = ST_CLEAR;
                end else if (gamemode == GM_RUN) begin
                    if (tick_pend_r || frame_tick) begin
                        state_s = ST_SCROLL;
                    end else if (spawn_req) begin
                        state_s = ST_SPAWN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCROLL: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SCROLL;
                end
            end
            ST_SPAWN: state_s = ST_IDLE;
            ST_CLEAR: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Sweep index, tick bookkeeping and the spawn handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r          <= {IDX_W{1'b0}};
            tick_pend_r    <= 1'b0;
            tick_overrun_r <= 1'b0;
            spawn_ack_r    <= 1'b0;
            spawn_ok_r     <= 1'b0;
            spawn_slot_r   <= {IDX_W{1'b0}};
            spawn_right_r  <= {X_W{1'b0}};
            spawn_top_r    <= {Y_W{1'b0}};
            spawn_bot_r    <= {Y_W{1'b0}};
        end else begin
            spawn_ack_r <= go_spawn_s;
            spawn_ok_r  <= go_spawn_s & spawn_valid_s;
            // The request is captured on entry so the write does not depend on the requester.
            if (go_spawn_s) begin
                spawn_slot_r  <= free_idx_s;
                spawn_right_r <= spawn_right_edge(SCREEN_X, spawn_width);
                spawn_top_r   <= spawn_y_top;
                spawn_bot_r   <= spawn_y_bot;
            end
            if ((state_r == ST_SCROLL) && (idx_r != LAST_IDX)) begin
                idx_r <= idx_r + IDX_W'(1);
            end else begin
                idx_r <= {IDX_W{1'b0}};
            end
            case (state_r)
                ST_IDLE: begin
                    // A tick arriving while a pending one is consumed stays pending.
                    if ((gamemode == GM_RUN) && (tick_pend_r || frame_tick)) begin
                        tick_pend_r <= tick_pend_r & frame_tick;
                    end
                end
                ST_CLEAR: begin
                    tick_pend_r    <= 1'b0;
                    tick_overrun_r <= 1'b0;
                end
                default: begin
                    if (frame_tick && (gamemode == GM_RUN)) begin
                        if (tick_pend_r) begin
                            tick_overrun_r <= 1'b1;
                        end else begin
                            tick_pend_r <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Slot storage: scroll/retire one slot per sweep cycle, spawn writes, bulk clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                left_r[i]  <= {X_W{1'b0}};
                right_r[i] <= {X_W{1'b0}};
                top_r[i]   <= {Y_W{1'b0}};
                bot_r[i]   <= {Y_W{1'b0}};
            end
            active_r <= {N_SLOTS{1'b0}};
        end else begin
            case (state_r)
                ST_SCROLL: begin
                    if (active_r[idx_r]) begin
                        if (right_r[idx_r] <= SPEED_X) begin
                            left_r[idx_r]   <= {X_W{1'b0}};
                            right_r[idx_r]  <= {X_W{1'b0}};
                            top_r[idx_r]    <= {Y_W{1'b0}};
                            bot_r[idx_r]    <= {Y_W{1'b0}};
                            active_r[idx_r] <= 1'b0;
                        end else begin
                            right_r[idx_r] <= right_r[idx_r] - SPEED_X;
                            left_r[idx_r]  <= (left_r[idx_r] >= SPEED_X) ? (left_r[idx_r] - SPEED_X)
                                                                         : {X_W{1'b0}};
                        end
                    end
                end
                ST_SPAWN: begin
                    if (spawn_ok_r) begin
                        left_r[spawn_slot_r]   <= SCREEN_X;
                        right_r[spawn_slot_r]  <= spawn_right_r;
                        top_r[spawn_slot_r]    <= spawn_top_r;
                        bot_r[spawn_slot_r]    <= spawn_bot_r;
                        active_r[spawn_slot_r] <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    for (int i = 0; i < N_SLOTS; i++) begin
                        left_r[i]  <= {X_W{1'b0}};
                        right_r[i] <= {X_W{1'b0}};
                        top_r[i]   <= {Y_W{1'b0}};
                        bot_r[i]   <= {Y_W{1'b0}};
                    end
                    active_r <= {N_SLOTS{1'b0}};
                end
                default: begin
                end
            endcase
        end
    end

    // Flatten the slot registers onto the renderer buses.
    always_comb begin
        obstacle_x = {(N_SLOTS*X_FIELD_W){1'b0}};
        obstacle_y = {(N_SLOTS*Y_FIELD_W){1'b0}};
        for (int i = 0; i < N_SLOTS; i++) begin
            obstacle_x[i*X_FIELD_W +: X_W]       = left_r[i];
            obstacle_x[i*X_FIELD_W + X_W +: X_W] = right_r[i];
            obstacle_y[i*Y_FIELD_W +: Y_W]       = top_r[i];
            obstacle_y[i*Y_FIELD_W + Y_W +: Y_W] = bot_r[i];
        end
    end

    assign spawn_ack    = spawn_ack_r;
    assign spawn_ok     = spawn_ok_r;
    assign active_mask  = active_r;
    assign tick_overrun = tick_overrun_r;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: a frame-level slot model predicts spawn
// results and bus contents; a monitor pops predictions whenever spawn_ack appears.
module tb_obstacle_scheduler;

    localparam int SPEED  = 4;
    localparam int SCREEN = 640;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   gamemode;
    logic         frame_tick;
    logic         spawn_req;
    logic [9:0]   spawn_width;
    logic [8:0]   spawn_y_top;
    logic [8:0]   spawn_y_bot;
    logic         spawn_ack;
    logic         spawn_ok;
    logic [199:0] obstacle_x;
    logic [179:0] obstacle_y;
    logic [9:0]   active_mask;
    logic         tick_overrun;

    obstacle_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gamemode     (gamemode),
        .frame_tick   (frame_tick),
        .spawn_req    (spawn_req),
        .spawn_width  (spawn_width),
        .spawn_y_top  (spawn_y_top),
        .spawn_y_bot  (spawn_y_bot),
        .spawn_ack    (spawn_ack),
        .spawn_ok     (spawn_ok),
        .obstacle_x   (obstacle_x),
        .obstacle_y   (obstacle_y),
        .active_mask  (active_mask),
        .tick_overrun (tick_overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int m_left[10];
    int m_right[10];
    int m_top[10];
    int m_bot[10];
    bit m_act[10];

    typedef struct {
        bit           ok;
        logic [199:0] x;
        logic [179:0] y;
        logic [9:0]   m;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 10; i++) begin
            m_left[i] = 0; m_right[i] = 0; m_top[i] = 0; m_bot[i] = 0; m_act[i] = 1'b0;
        end
    endfunction

    // One whole frame of scrolling applied to every live obstacle.
    function automatic void model_tick();
        for (int i = 0; i < 10; i++) begin
            if (m_act[i]) begin
                if (m_right[i] <= SPEED) begin
                    m_left[i] = 0; m_right[i] = 0; m_top[i] = 0; m_bot[i] = 0; m_act[i] = 1'b0;
                end else begin
                    m_right[i] = m_right[i] - SPEED;
                    m_left[i]  = (m_left[i] >= SPEED) ? m_left[i] - SPEED : 0;
                end
            end
        end
    endfunction

    function automatic bit model_spawn(input int w, input int t, input int b);
        int f = -1;
        for (int i = 0; i < 10; i++) begin
            if (!m_act[i] && f < 0) f = i;
        end
        if (w == 0 || t >= b || f < 0) return 1'b0;
        m_left[f]  = SCREEN;
        m_right[f] = (SCREEN + w > 1023) ? 1023 : SCREEN + w;
        m_top[f]   = t;
        m_bot[f]   = b;
        m_act[f]   = 1'b1;
        return 1'b1;
    endfunction

    function automatic logic [199:0] model_x();
        logic [199:0] r = 200'd0;
        for (int i = 0; i < 10; i++) begin
            r[i*20 +: 10]      = 10'(m_left[i]);
            r[i*20 + 10 +: 10] = 10'(m_right[i]);
        end
        return r;
    endfunction

    function automatic logic [179:0] model_y();
        logic [179:0] r = 180'd0;
        for (int i = 0; i < 10; i++) begin
            r[i*18 +: 9]     = 9'(m_top[i]);
            r[i*18 + 9 +: 9] = 9'(m_bot[i]);
        end
        return r;
    endfunction

    function automatic logic [9:0] model_mask();
        logic [9:0] r = 10'd0;
        for (int i = 0; i < 10; i++) r[i] = m_act[i];
        return r;
    endfunction

    task automatic check_snapshot(input string tag);
        @(negedge clk);
        chk({tag, "_x"}, obstacle_x, model_x());
        chk({tag, "_y"}, 200'(obstacle_y), 200'(model_y()));
        chk({tag, "_mask"}, 200'(active_mask), 200'(model_mask()));
    endtask

    task automatic wait_ack(input int start, output int lat);
        lat = start;
        do begin
            @(negedge clk);
            lat++;
        end while (spawn_ack !== 1'b1 && lat < 60);
        if (spawn_ack !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout: spawn_ack=%b after %0d cycles, required 1", spawn_ack, lat);
        end
    endtask

    task automatic do_spawn(input int w, input int t, input int b, output int lat);
        bit ok;
        ok = model_spawn(w, t, b);
        exp_q.push_back('{ok, model_x(), model_y(), model_mask()});
        @(posedge clk); #1;
        spawn_width = 10'(w); spawn_y_top = 9'(t); spawn_y_bot = 9'(b); spawn_req = 1'b1;
        wait_ack(0, lat);
        @(posedge clk); #1 spawn_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_tick();
        model_tick();
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    task automatic rand_spawn();
        int w, t, b, lat;
        w = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 1023));
        t = $urandom_range(0, 510);
        b = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, t)) : int'($urandom_range(t + 1, 511));
        do_spawn(w, t, b, lat);
    endtask

    // Monitor: every spawn_ack must match the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (spawn_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: spawn_ack=1 spawn_ok=%b, required no ack", spawn_ok);
                end else begin
                    e = exp_q.pop_front();
                    chk("spawn_ok", 200'(spawn_ok), 200'(e.ok));
                    @(negedge clk);
                    chk("spawn_x", obstacle_x, e.x);
                    chk("spawn_y", 200'(obstacle_y), 200'(e.y));
                    chk("spawn_mask", 200'(active_mask), 200'(e.m));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  ok;
        gamemode = 2'b00; frame_tick = 1'b0; spawn_req = 1'b0;
        spawn_width = 10'd0; spawn_y_top = 9'd0; spawn_y_bot = 9'd0;
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_x", obstacle_x, 200'd0);
        chk("rst_y", 200'(obstacle_y), 200'd0);
        chk("rst_mask", 200'(active_mask), 200'd0);
        chk("rst_ack", 200'(spawn_ack), 200'd0);
        chk("rst_ok", 200'(spawn_ok), 200'd0);
        chk("rst_overrun", 200'(tick_overrun), 200'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 gamemode = 2'b01;

        // First spawn lands in slot 0
        do_spawn(40, 100, 140, lat);
        chk("first_ack_latency", 200'(lat), 200'd2);
        @(negedge clk);
        chk("slot0_left", 200'(obstacle_x[9:0]), 200'd640);
        chk("slot0_right", 200'(obstacle_x[19:10]), 200'd680);
        chk("slot0_y", 200'(obstacle_y[17:0]), 200'({9'd140, 9'd100}));
        chk("slot0_mask", 200'(active_mask), 200'd1);

        // Long scroll run with random spawns; slot 1 walks to the left clamp and retires
        do_spawn(6, 10, 20, lat);
        for (int k = 1; k <= 175; k++) begin
            do_tick();
            check_snapshot("tick");
            if (k == 161) begin
                chk("clamp_left", 200'(obstacle_x[29:20]), 200'd0);
                chk("clamp_right", 200'(obstacle_x[39:30]), 200'd2);
            end
            if (k == 162) begin
                chk("retire_mask", 200'(active_mask[1]), 200'd0);
                chk("retire_x", 200'(obstacle_x[39:20]), 200'd0);
            end
            if ($urandom_range(0, 3) == 0) rand_spawn();
        end

        // Three ticks two cycles apart: one sweep, one pending, one lost
        model_tick();
        model_tick();
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        repeat (30) @(posedge clk);
        check_snapshot("overrun_sweeps");
        chk("overrun_set", 200'(tick_overrun), 200'd1);
        @(posedge clk); #1 gamemode = 2'b00;
        repeat (4) @(posedge clk);
        #1 gamemode = 2'b01;
        model_clear();
        check_snapshot("clear");
        chk("overrun_cleared", 200'(tick_overrun), 200'd0);

        // Tick and spawn together: sweep first, then an unscrolled spawn
        for (int i = 0; i < 3; i++) do_spawn(30 + i, 50, 60, lat);
        model_tick();
        ok = model_spawn(100, 200, 300);
        exp_q.push_back('{ok, model_x(), model_y(), model_mask()});
        @(posedge clk); #1;
        frame_tick = 1'b1; spawn_width = 10'd100; spawn_y_top = 9'd200; spawn_y_bot = 9'd300; spawn_req = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 frame_tick = 1'b0;
        wait_ack(1, lat);
        chk("tick_then_spawn_latency", 200'(lat), 200'd13);
        @(posedge clk); #1 spawn_req = 1'b0;
        repeat (2) @(posedge clk);
        check_snapshot("tick_then_spawn");

        // Fill every slot, then one more request is dropped
        while (model_mask() != 10'h3FF) rand_spawn();
        do_spawn(50, 10, 20, lat);
        @(negedge clk);
        chk("full_mask", 200'(active_mask), 200'h3FF);

        // Pause and game over freeze everything; resume acks promptly
        @(posedge clk); #1 gamemode = 2'b00;
        repeat (3) @(posedge clk);
        #1 gamemode = 2'b01;
        model_clear();
        do_spawn(20, 30, 40, lat);
        do_spawn(25, 35, 45, lat);
        @(posedge clk); #1;
        gamemode = 2'b10; spawn_width = 10'd60; spawn_y_top = 9'd70; spawn_y_bot = 9'd90; spawn_req = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            frame_tick = (c % 4 == 1) ? 1'b1 : 1'b0;
            if (c == 15) gamemode = 2'b11;
        end
        frame_tick = 1'b0;
        check_snapshot("paused");
        ok = model_spawn(60, 70, 90);
        exp_q.push_back('{ok, model_x(), model_y(), model_mask()});
        @(posedge clk); #1 gamemode = 2'b01;
        wait_ack(0, lat);
        chk("resume_ack_within_2", 200'(lat <= 2), 200'd1);
        @(posedge clk); #1 spawn_req = 1'b0;
        repeat (3) @(posedge clk);
        check_snapshot("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
